dce_uart_rx: RTL and testbench

//  DCE-side serial receiver that consumes the light-UART transactor's txd line and

---
 rtl/dce_uart_pkg.sv | 14 +
 rtl/dce_rx_fifo.sv | 53 +++++
 rtl/dce_uart_rx.sv | 149 ++++++++++++++
 tb/tb_dce_uart_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dce_uart_pkg.sv
// Shared types and constants for the DCE-side serial receiver.
package dce_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int DBR_W     = 32;

  function automatic logic [DBR_W-1:0] clamp_div(input logic [DBR_W-1:0] dbr,
                                                 input logic [DBR_W-1:0] min_div);
    return (dbr < min_div) ? min_div : dbr;
  endfunction

endpackage

// File: rtl/dce_rx_fifo.sv
// Synchronous show-ahead FIFO; head word is read combinationally from storage.
module dce_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok, pop_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == DEPTH_L);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/dce_uart_rx.sv
// 8N1 receiver: synchroniser, bit-timing FSM, receive FIFO and cts flow control.
module dce_uart_rx
  import dce_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CTS_HI_MARK = 12,
  parameter int CTS_LO_MARK = 4,
  parameter int MIN_DIV     = 4
) (
  input  logic                          clock10M,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic [31:0]                   dbr,
  output logic                          cts,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] HI_L = LW'(CTS_HI_MARK);
  localparam logic [LW-1:0] LO_L = LW'(CTS_LO_MARK);

  logic                  sync1_reg, sync2_reg, rx_s;
  rx_state_e             state_reg, state_next;
  logic [DBR_W-1:0]      cnt_reg, cnt_next, div_reg, div_next;
  logic [2:0]            bit_reg, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  push, fe_next, ov_next;
  logic                  fe_reg, ov_reg, cts_reg;
  logic                  fifo_full, fifo_empty, pop;

  assign rx_s = sync2_reg;

  always_ff @(posedge clock10M) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      div_reg   <= DBR_W'(MIN_DIV);
      bit_reg   <= '0;
      shift_reg <= '0;
      fe_reg    <= 1'b0;
      ov_reg    <= 1'b0;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      fe_reg    <= fe_next;
      ov_reg    <= ov_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    fe_next    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
          div_next   = clamp_div(dbr, DBR_W'(MIN_DIV));
        end
      end
      START: begin
        // Mid-start-bit check rejects short low glitches silently.
        if (cnt_reg == (div_reg >> 1) - 1'b1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == div_reg - 1'b1) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == div_reg - 1'b1) begin
          cnt_next = '0;
          if (rx_s) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign ov_next   = push & fifo_full & ~pop;

  dce_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clock10M),
    .srst  (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shift_reg),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Hysteresis band between the marks keeps cts from chattering.
  always_ff @(posedge clock10M) begin
    if (reset)                   cts_reg <= 1'b0;
    else if (fifo_level >= HI_L) cts_reg <= 1'b0;
    else if (fifo_level <= LO_L) cts_reg <= 1'b1;
  end

  assign cts       = cts_reg;
  assign frame_err = fe_reg;
  assign overrun   = ov_reg;

endmodule

// File: tb/tb_dce_uart_rx.sv
// Scoreboard bench for dce_uart_rx: a serial line driver feeds an expected-byte queue, a monitor checks pops.
module tb_dce_uart_rx;

  localparam int DEPTH = 16;

  logic        clock10M = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic [31:0] dbr = 32'd16;
  logic        out_ready = 1'b0;
  logic        cts, out_valid, frame_err, overrun;
  logic [7:0]  out_data;
  logic [4:0]  fifo_level;

  dce_uart_rx dut (
    .clock10M   (clock10M),
    .reset      (reset),
    .rxd        (rxd),
    .dbr        (dbr),
    .cts        (cts),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  always #5 clock10M = ~clock10M;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  int rdy_mode = 0, pulse_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge clock10M) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic int bit_cycles(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  // Model: a good frame adds a byte unless 16 are already waiting (then an overrun);
  // a bad stop bit adds one framing error and no byte.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bitc);
    if (stop_bit) begin
      if (exp_q.size() >= DEPTH) exp_ov++;
      else                       exp_q.push_back(b);
    end else begin
      exp_fe++;
    end
    rxd = 1'b0;
    repeat (bitc) @(negedge clock10M);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bitc) @(negedge clock10M);
    end
    rxd = stop_bit;
    repeat (bitc) @(negedge clock10M);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits, input int bitc);
    rxd = 1'b0;
    repeat (bitc) @(negedge clock10M);
    for (int i = 0; i < nbits; i++) begin
      rxd = b[i];
      repeat (bitc) @(negedge clock10M);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock10M);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clock10M);
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_pulses(input int n);
    int t;
    pulse_cnt = n;
    rdy_mode  = 3;
    t = 0;
    while (pulse_cnt != 0 && t < 200) begin
      @(negedge clock10M);
      t++;
    end
    chk("pulse_done", pulse_cnt, 0);
    idle(4);
  endtask

  // Consumer ready driver: 0 off, 1 on, 2 random, 3 counted single pops.
  initial forever begin
    @(negedge clock10M);
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (pulse_cnt > 0);
        if (pulse_cnt > 0) pulse_cnt--;
      end
    endcase
  end

  // Monitor: counts flag pulses and scores every accepted byte against the queue.
  initial forever begin
    @(negedge clock10M);
    #1;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = out_valid;
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got 0x%02h, expected no byte", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int d, bc;
    logic [7:0] b;
    logic good;

    // Reset state
    idle(3);
    chk("rst_cts", cts, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    idle(1);
    chk("cts_after_reset", cts, 1);

    // 0x55 at 16 cycles/bit, with latency window
    rdy_mode = 1;
    dbr = 32'd16;
    idle(20);
    start = cyc;
    send_byte(8'h55, 1'b1, 16);
    idle(40);
    chk("latency_window", ((rise_cyc - start) >= 150 && (rise_cyc - start) <= 165) ? 1 : 0, 1);
    wait_drain("drain_55");

    // dbr below minimum is clamped to 4 cycles/bit
    dbr = 32'd2;
    idle(10);
    send_byte(8'hA3, 1'b1, bit_cycles(2));
    idle(20);
    wait_drain("drain_a3");

    // Two-cycle glitch is not a start bit
    dbr = 32'd16;
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20 * 16);
    chk("glitch_level", fifo_level, 0);
    chk("glitch_fe", fe_cnt, exp_fe);

    // Bad stop bit followed by a long break: one error only
    send_byte(8'h0F, 1'b0, 16);
    idle(50 * 16);
    rxd = 1'b1;
    idle(32);
    chk("break_fe", fe_cnt, exp_fe);
    chk("break_level", fifo_level, 0);
    send_byte(8'h81, 1'b1, 16);
    idle(20);
    wait_drain("drain_81");

    // Random frames, divisors and consumer back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 25; n++) begin
      d    = int'($urandom_range(0, 24));
      bc   = bit_cycles(d);
      dbr  = 32'(d);
      b    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      idle(4 + int'($urandom_range(0, 20)));
      send_byte(b, good, bc);
      if (!good) begin
        rxd = 1'b1;
        idle(bc);
      end
    end
    idle(40);
    rdy_mode = 1;
    wait_drain("drain_random");
    chk("random_fe", fe_cnt, exp_fe);
    chk("random_ov", ov_cnt, exp_ov);

    // Flood with no consumer: cts hysteresis and overrun
    rdy_mode = 0;
    dbr = 32'd16;
    idle(10);
    for (int i = 1; i <= 17; i++) begin
      send_byte(8'(i * 7 + 3), 1'b1, 16);
      if (i == 11) chk("cts_at_11", cts, 1);
      if (i == 12) chk("cts_at_12", cts, 0);
      if (i == 16) chk("level_full", fifo_level, exp_q.size());
    end
    idle(20);
    chk("flood_ov", ov_cnt, exp_ov);
    chk("flood_level", fifo_level, exp_q.size());
    chk("flood_head", out_data, exp_q[0]);
    wait_pulses(11);
    chk("level_5", fifo_level, exp_q.size());
    chk("cts_hold_at_5", cts, 0);
    wait_pulses(1);
    chk("level_4", fifo_level, exp_q.size());
    chk("cts_at_4", cts, 1);
    rdy_mode = 1;
    wait_drain("drain_flood");

    // Reset mid-frame flushes FIFO and aborts frame silently
    rdy_mode = 0;
    idle(5);
    send_byte(8'h11, 1'b1, 16);
    idle(10);
    chk("pre_reset_level", fifo_level, exp_q.size());
    send_partial(8'h3C, 4, 16);
    rxd = 1'b1;
    reset = 1'b1;
    exp_q.delete();
    idle(1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cts", cts, 0);
    chk("mid_rst_fe", frame_err, 0);
    chk("mid_rst_ov", overrun, 0);
    reset = 1'b0;
    idle(200);
    chk("post_rst_fe", fe_cnt, exp_fe);
    chk("post_rst_ov", ov_cnt, exp_ov);
    chk("post_rst_cts", cts, 1);
    rdy_mode = 1;
    send_byte(8'h7E, 1'b1, 16);
    idle(20);
    wait_drain("drain_7e");
    chk("final_fe", fe_cnt, exp_fe);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
